// File: rtl/gpio_bus_arbiter_pkg.sv
// Shared types and constants for the GPIO register-bus arbiter.
package gpio_arb_pkg;

  localparam int unsigned GPIO_ADDR_W = 32;
  localparam int unsigned GPIO_DATA_W = 32;
  localparam int unsigned GPIO_BE_W   = 4;

  localparam logic RESP_OK      = 1'b0;
  localparam logic RESP_TIMEOUT = 1'b1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_e;

endpackage

// File: rtl/gpio_bus_arbiter_if.sv
// Internal GPIO register bus; master side is the arbiter, slave side is gpio_regs.
interface gpio_bus_arbiter_if;
  import gpio_arb_pkg::*;

  logic [GPIO_ADDR_W-1:0] reg_addr;
  logic [GPIO_DATA_W-1:0] reg_wdata;
  logic [GPIO_BE_W-1:0]   reg_be;
  logic                   reg_we;
  logic                   reg_re;
  logic [GPIO_DATA_W-1:0] reg_rdata;
  logic                   reg_ack;

  modport master (
    output reg_addr, reg_wdata, reg_be, reg_we, reg_re,
    input  reg_rdata, reg_ack
  );

  modport slave (
    input  reg_addr, reg_wdata, reg_be, reg_we, reg_re,
    output reg_rdata, reg_ack
  );

endinterface

// File: rtl/gpio_bus_arbiter_rr_picker.sv
// Combinational round-robin picker: first asserted request after last_grant, wrapping.
module gpio_rr_picker #(
  parameter int unsigned N     = 3,
  parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_grant,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = IDX_W'((32'(last_grant) + i) % N);
      if (!any && req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
    if (any) begin
      grant[idx] = 1'b1;
    end
  end

endmodule

// File: rtl/gpio_bus_arbiter.sv
// Round-robin arbiter serialising requester accesses onto the GPIO register bus,
// with an optional ack timeout.
module gpio_bus_arbiter
  import gpio_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 3,
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_we,
  input  logic [NUM_REQ-1:0][GPIO_ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][GPIO_DATA_W-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0][GPIO_BE_W-1:0]     req_be,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [GPIO_DATA_W-1:0]                rsp_rdata,
  output logic                                  rsp_err,
  gpio_bus_arbiter_if.master                    reg_bus
);

  localparam int unsigned     IDX_W    = $clog2(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NUM_REQ - 1);
  localparam logic [7:0]      TO_LAST  = 8'(TIMEOUT_CYC - 1);

  arb_state_e             state_q, state_d;
  logic [IDX_W-1:0]       last_grant_q;
  logic [IDX_W-1:0]       idx_q;
  logic                   we_q;
  logic [GPIO_ADDR_W-1:0] addr_q;
  logic [GPIO_DATA_W-1:0] wdata_q;
  logic [GPIO_BE_W-1:0]   be_q;
  logic [7:0]             cnt_q;
  logic [GPIO_DATA_W-1:0] rdata_q;
  logic                   err_q;

  logic [NUM_REQ-1:0]     pick_grant;
  logic [IDX_W-1:0]       pick_idx;
  logic                   pick_any;
  logic                   timeout_hit;

  gpio_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .grant      (pick_grant),
    .idx        (pick_idx),
    .any        (pick_any)
  );

  // Counter value in the last strobe cycle before a timeout is declared.
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt_q == TO_LAST);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= LAST_RST;
      idx_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      be_q         <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= RESP_OK;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (pick_any) begin
            last_grant_q <= pick_idx;
            idx_q        <= pick_idx;
            we_q         <= req_we[pick_idx];
            addr_q       <= req_addr[pick_idx];
            wdata_q      <= req_wdata[pick_idx];
            be_q         <= req_be[pick_idx];
          end
        end
        ACCESS: begin
          if (reg_bus.reg_ack) begin
            rdata_q <= we_q ? '0 : reg_bus.reg_rdata;
            err_q   <= RESP_OK;
          end else if (timeout_hit) begin
            rdata_q <= '0;
            err_q   <= RESP_TIMEOUT;
          end else if (TIMEOUT_CYC != 0) begin
            cnt_q <= cnt_q + 8'd1;
          end
        end
        RESP: begin
          cnt_q <= '0;
        end
        default: begin
          cnt_q <= '0;
        end
      endcase
    end
  end

  always_comb begin
    state_d           = state_q;
    req_ready         = '0;
    rsp_valid         = '0;
    rsp_rdata         = '0;
    rsp_err           = RESP_OK;
    reg_bus.reg_addr  = '0;
    reg_bus.reg_wdata = '0;
    reg_bus.reg_be    = '0;
    reg_bus.reg_we    = 1'b0;
    reg_bus.reg_re    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          req_ready = pick_grant;
          state_d   = ACCESS;
        end
      end
      ACCESS: begin
        reg_bus.reg_addr  = addr_q;
        reg_bus.reg_wdata = wdata_q;
        reg_bus.reg_be    = be_q;
        reg_bus.reg_we    = we_q;
        reg_bus.reg_re    = !we_q;
        if (reg_bus.reg_ack || timeout_hit) begin
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid[idx_q] = 1'b1;
        rsp_rdata        = rdata_q;
        rsp_err          = err_q;
        state_d          = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
